circular_fifo_core: RTL
=======================

// Module: circular_fifo_core
// PURPOSE
// - Circular-buffer FIFO storage consumed by the Avalon CSR front end (fifo_csr): accepts its wr_en/rd_en/fifo_input_data.
// - Returns full/empty/fifo_output_data to it.
// - Register-array storage with read/write pointers and an occupancy counter.
// - Show-ahead (first-word-fall-through): head word is always presented; rd_en pops it.
// - Sticky overflow/underflow error flags for the CSR status register.
// PARAMETERS
// - WIDTH   8    data word width in bits
// - DEPTH   16   number of entries; any value >= 2, power of two not required
// - PTR_W   $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
// - clk               in   1          single clock, all state updates on rising edge
// - reset             in   1          synchronous, active-high
// - wr_en             in   1          push fifo_input_data this cycle
// - fifo_input_data   in   WIDTH      write data
// - rd_en             in   1          pop head word this cycle
// - fifo_output_data  out  WIDTH      head word (show-ahead); 0 when empty
// - full              out  1          registered, count == DEPTH
// - empty             out  1          registered, count == 0
// - count             out  PTR_W+1    registered occupancy, 0..DEPTH
// - overflow          out  1          sticky: write attempted while full
// - underflow         out  1          sticky: read attempted while empty
// - clr_err           in   1          1-cycle pulse clears overflow/underflow
// BEHAVIOUR
// - Reset (synchronous, active-high; wins over all other inputs):
//   - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = underflow = 0.
//   - Storage array is not cleared.
// - push = wr_en & ~full; pop = rd_en & ~empty.
//   - Both use the registered flags at the start of the cycle.
// - push: mem[wr_ptr] <= fifo_input_data; wr_ptr advances.
// - pop: rd_ptr advances.
// - Pointer wrap: on advance, a pointer at DEPTH-1 goes to 0, else +1.
//   - Explicit compare, no reliance on natural overflow.
// - count update:
//   - push only: +1
//   - pop only: -1
//   - both or neither: unchanged
// - full/empty recomputed from the next count; both are valid in the cycle after the edge.
// - fifo_output_data = mem[rd_ptr] when ~empty, else 0.
//   - Combinational from registers.
//   - A word written at edge N is visible after edge N; empty drops at the same edge.
// - Simultaneous wr_en & rd_en:
//   - empty: write accepted, read rejected, underflow set; count -> 1.
//   - full: read accepted, write rejected, overflow set; count -> DEPTH-1.
//   - otherwise: both accepted; count unchanged; output advances to the next word.
// - Error flags:
//   - overflow <= 1 on wr_en & full.
//   - underflow <= 1 on rd_en & empty.
//   - clr_err clears both.
//   - Same-cycle clr_err and a new error event: the set wins.
//   - Rejected operations never alter pointers, count or storage.
// - Reset asserted mid-stream: contents discarded at that edge; empty = 1 in the next cycle.
// - No combinational path from wr_en/rd_en to any output.
// TESTING
// - Reset check: assert reset 2 cycles -> empty=1, full=0, count=0, fifo_output_data=0x00, overflow=underflow=0.
// - Single word: push 0xA5 -> next cycle empty=0, count=1, fifo_output_data=0xA5; pop -> empty=1, fifo_output_data=0x00.
// - Fill, wrap and drain:
//   - Push 0x00..0x0F (DEPTH=16) -> full=1, count=16.
//   - Pop 4, push 0x10..0x13 -> full again.
//   - Drain -> reads 0x04..0x13 in order, then empty=1.
// - Overflow/underflow:
//   - wr_en while full -> overflow=1, count stays 16, data intact.
//   - rd_en while empty -> underflow=1.
//   - clr_err -> both 0.
// - Simultaneous: wr_en & rd_en at count=5 -> count stays 5, head advances; at empty -> count=1, underflow=1; at full -> count=15, overflow=1.
// - Mid-operation reset: reset at count=7 -> next cycle empty=1, count=0; subsequent push 0x3C reads back 0x3C.

Source files
------------

// File: rtl/circular_fifo_core.sv
// Show-ahead circular-buffer FIFO with registered occupancy flags and sticky
// overflow/underflow error bits for a CSR front end.
module circular_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] fifo_input_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] fifo_output_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [PTR_W:0]   count_next;

  function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Acceptance is decided only by the registered flags, so no input reaches an output.
  always_comb begin
    push       = wr_en & ~full;
    pop        = rd_en & ~empty;
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= ptr_advance(wr_ptr);
      if (pop)
        rd_ptr <= ptr_advance(rd_ptr);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
      // A new error event in the same cycle as clr_err keeps the flag set.
      if (wr_en && full)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (rd_en && empty)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr] <= fifo_input_data;
  end

  assign fifo_output_data = empty ? '0 : mem[rd_ptr];

endmodule
